ct_bit_deserializer: RTL and testbench



---
 rtl/ct_bit_deserializer.sv | 228 ++++++++++++++++++++++
 tb/tb_ct_bit_deserializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ct_bit_deserializer.sv
// ---------------------------------------------------------------------------
// ct_bit_deserializer
//
// Receive end of a 1-bit control-gated serial stream. While `ct` is high the
// sender drives one data bit per cycle on `in`; bits are collected LSB-first
// into a WIDTH-bit word. Each completed word is pushed into a 2-entry FIFO
// that is drained through a valid/ready handshake. A frame that ends early
// (ct drops with a partial word) pulses frag_err. A word that completes while
// the FIFO is full and not being popped is dropped and sets the sticky
// overflow flag.
//
// Optional feature (macro CT_PARITY_CHECK_EN):
//   Each frame carries one extra even-parity bit after the WIDTH data bits.
//   The word is pushed only if the parity matches; otherwise it is dropped and
//   parity_err pulses. Adds the parity_err output port.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   ct         in   frame strobe, a data bit is present on `in` when high
//   in         in   serial data bit
//   out_ready  in   consumer accepts the head word
//   out_valid  out  head word present
//   out_data   out  head word (held while not popped)
//   frag_err   out  one-cycle pulse, frame aborted with a partial word
//   overflow   out  sticky, a completed word was dropped (buffer full)
//   busy       out  high while a frame is being shifted in
//   parity_err out  one-cycle pulse, parity mismatch (CT_PARITY_CHECK_EN only)
//
// States:
//   IDLE   | waiting for the first bit of a frame
//   SHIFT  | collecting data bits 1..WIDTH-1
//   PARITY | waiting for the even-parity bit (CT_PARITY_CHECK_EN only)
// ---------------------------------------------------------------------------
module ct_bit_deserializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ct,
    input  logic             in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             frag_err,
    output logic             overflow,
`ifdef CT_PARITY_CHECK_EN
    output logic             busy,
    output logic             parity_err
`else
    output logic             busy
`endif
);

`ifdef CT_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               frag_q, frag_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic [WIDTH-1:0]   tail_q, tail_d;
    logic [1:0]         count_q, count_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
`ifdef CT_PARITY_CHECK_EN
    logic               par_err_q, par_err_d;
`endif

    logic               word_done;
    logic [WIDTH-1:0]   push_word;
    logic               pop;

    // Receive FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        frag_d    = 1'b0;
        word_done = 1'b0;
        push_word = shift_q;
`ifdef CT_PARITY_CHECK_EN
        par_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ct) begin
                    // first bit overwrites the whole register so stale
                    // upper bits from the previous word never leak through
                    shift_d = WIDTH'(in);
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ct) begin
                    shift_d = shift_q | (WIDTH'(in) << cnt_q);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_d = '0;
`ifdef CT_PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        word_done = 1'b1;
                        push_word = shift_d;
                        state_d   = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    frag_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
`ifdef CT_PARITY_CHECK_EN
            PARITY: begin
                state_d = IDLE;
                if (ct) begin
                    if ((^shift_q ^ in) == 1'b0) begin
                        word_done = 1'b1;
                        push_word = shift_q;
                    end else begin
                        par_err_d = 1'b1;
                    end
                end else begin
                    frag_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == SHIFT);
    end

    // Two-entry output FIFO: head_q is always the presented word, tail_q the
    // second entry. A pop and a push on the same edge never overflow.
    assign pop = valid_q & out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (count_q)
            2'd0: begin
                if (word_done) begin
                    head_d  = push_word;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (word_done && pop) begin
                    head_d = push_word;
                end else if (pop) begin
                    count_d = 2'd0;
                end else if (word_done) begin
                    tail_d  = push_word;
                    count_d = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (word_done) begin
                        tail_d = push_word;
                    end else begin
                        count_d = 2'd1;
                    end
                end else if (word_done) begin
                    ovf_d = 1'b1;
                end
            end
        endcase
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            frag_q    <= 1'b0;
            busy_q    <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 2'd0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef CT_PARITY_CHECK_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            frag_q    <= frag_d;
            busy_q    <= busy_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
`ifdef CT_PARITY_CHECK_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = head_q;
    assign frag_err   = frag_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;
`ifdef CT_PARITY_CHECK_EN
    assign parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_ct_bit_deserializer.sv
// ---------------------------------------------------------------------------
// Bench for ct_bit_deserializer (default build, WIDTH=8).
// Frame-level reference model: bits of the current frame are kept in a queue,
// a full frame becomes a word, and buffer occupancy is tracked as a count.
// Accepted words go into exp_q; a separate monitor pops exp_q on every DUT
// handshake and compares the data.
// ---------------------------------------------------------------------------
module tb_ct_bit_deserializer;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         ct;
    logic         in;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         frag_err;
    logic         overflow;
    logic         busy;

    int vectors = 0;
    int errs    = 0;

    ct_bit_deserializer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .ct        (ct),
        .in        (in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .frag_err  (frag_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model state
    bit           chk_en = 1'b0;
    int           occ    = 0;
    bit           m_ovf  = 1'b0;
    bit           m_frag = 1'b0;
    bit           m_busy = 1'b0;
    bit           fbits[$];
    logic [W-1:0] exp_q[$];

    task automatic check1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // status checks, then advance the model with the inputs that the next
    // rising edge will see
    always @(negedge clk) begin
        logic [W-1:0] word;
        bit           have_word;
        int           n;
        if (chk_en) begin
            check1("out_valid", out_valid, occ > 0);
            check1("overflow", overflow, m_ovf);
            check1("frag_err", frag_err, m_frag);
            check1("busy", busy, m_busy);
        end
        if (rst === 1'b1) begin
            occ    = 0;
            m_ovf  = 1'b0;
            m_frag = 1'b0;
            fbits.delete();
            exp_q.delete();
            chk_en = 1'b1;
        end else begin
            have_word = 1'b0;
            word      = '0;
            m_frag    = 1'b0;
            if (ct === 1'b1) begin
                fbits.push_back(in === 1'b1);
                if (fbits.size() == W) begin
                    for (int i = 0; i < W; i++) word[i] = fbits[i];
                    have_word = 1'b1;
                    fbits.delete();
                end
            end else if (fbits.size() != 0) begin
                m_frag = 1'b1;
                fbits.delete();
            end
            n = occ - ((occ > 0 && out_ready === 1'b1) ? 1 : 0);
            if (have_word) begin
                if (n < 2) begin
                    exp_q.push_back(word);
                    n++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            occ = n;
        end
        m_busy = (fbits.size() != 0);
    end

    // data monitor: every handshake must match the oldest expected word
    always @(negedge clk) begin
        logic [W-1:0] w;
        if (chk_en && rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL out_data at %0t: got %h with no word expected", $time, out_data);
            end else begin
                w = exp_q.pop_front();
                if (out_data !== w) begin
                    errs++;
                    $display("FAIL out_data at %0t: got %h expected %h", $time, out_data, w);
                end
            end
        end
    end

    task automatic drive(input bit r, input bit c, input bit d, input bit rdy);
        rst       = r;
        ct        = c;
        in        = d;
        out_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rdy);
    endtask

    // rdy applies to bits 0..W-2, rdy_last to the final bit
    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit rdy_last);
        for (int i = 0; i < W; i++)
            drive(1'b0, 1'b1, w[i], (i == W - 1) ? rdy_last : rdy);
    endtask

    initial begin
        logic [W-1:0] a;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);

        // single word
        send_word(8'hA5, 1'b1, 1'b1);
        idle(3, 1'b1);

        // back-to-back words
        send_word(8'h3C, 1'b1, 1'b1);
        send_word(8'hC3, 1'b1, 1'b1);
        idle(3, 1'b1);

        // aborted frame then full frame
        a = 8'h1B;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, a[i], 1'b1);
        idle(2, 1'b1);
        send_word(8'hFF, 1'b1, 1'b1);
        idle(3, 1'b1);

        // overflow: third word dropped
        send_word(8'h01, 1'b0, 1'b0);
        send_word(8'h02, 1'b0, 1'b0);
        send_word(8'h03, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // push coinciding with pop while full
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h01, 1'b0, 1'b0);
        send_word(8'h02, 1'b0, 1'b0);
        send_word(8'h03, 1'b0, 1'b1);
        idle(5, 1'b1);

        // reset mid-frame with a word buffered
        send_word(8'h11, 1'b0, 1'b0);
        a = 8'h0F;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, a[i], 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 1'b1, 1'b1);
        idle(3, 1'b1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 8,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0);
        end
        idle(10, 1'b1);

        vectors++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d words still expected, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
